// File: rtl/wb_burst_master_if.sv
// Bundle of the command, write-data, read-return and Wishbone signals for wb_burst_master.
// The master modport is the burst engine's view; the slave modport is the surrounding system's view.
interface wb_burst_master_if #(
  parameter int AW = 26,
  parameter int DW = 32,
  parameter int LW = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [AW-1:0]     cmd_addr;
  logic [LW-1:0]     cmd_len;
  logic [DW/8-1:0]   cmd_sel;
  logic              wdat_valid;
  logic              wdat_ready;
  logic [DW-1:0]     wdat;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              rd_last;
  logic              busy;
  logic              err;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [AW-1:0]     wb_addr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic              wb_ack_i;
  logic [DW-1:0]     wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel,
    input  wdat_valid, wdat, wb_ack_i, wb_dat_i,
    output cmd_ready, wdat_ready, rd_valid, rd_data, rd_last, busy, err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel,
    output wdat_valid, wdat, wb_ack_i, wb_dat_i,
    input  cmd_ready, wdat_ready, rd_valid, rd_data, rd_last, busy, err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone burst master: one cyc per command, one non-pipelined strobe per beat, all outputs registered.
// Define WB_MASTER_TIMEOUT_EN to abort a burst when a beat waits TIMEOUT cycles for ack.
module wb_burst_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int LW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              RESETN,
  wb_burst_master_if.master bus
);
  localparam int BW = DW / 8;

  if ((DW != 8 && DW != 16 && DW != 32) || TIMEOUT < 1) begin : g_param_check
    $error("wb_burst_master: DW must be 8/16/32 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, FETCH, REQ, DONE} state_t;

  state_t          r_state;
  logic            r_we;
  logic [BW-1:0]   r_sel;
  logic [LW-1:0]   r_cnt;
  logic            r_cyc;
  logic            r_stb;
  logic            r_wb_we;
  logic [BW-1:0]   r_wb_sel;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdat;
  logic            r_cmd_ready;
  logic            r_wdat_ready;
  logic            r_rd_valid;
  logic [DW-1:0]   r_rd_data;
  logic            r_rd_last;
  logic            r_busy;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   r_to;
  logic            r_err;
`endif

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_sel     <= '0;
      r_addr       <= '0;
      r_wdat       <= '0;
      r_cmd_ready  <= 1'b0;
      r_wdat_ready <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_busy       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_to         <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      // Status pulses last exactly one cycle unless re-armed below.
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (r_cmd_ready && bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_we        <= bus.cmd_we;
            r_sel       <= bus.cmd_sel;
            r_cnt       <= bus.cmd_len;
            r_addr      <= bus.cmd_addr;
            r_cyc       <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            r_to        <= '0;
`endif
            if (bus.cmd_we) begin
              r_wdat_ready <= 1'b1;
              r_state      <= FETCH;
            end else begin
              r_stb    <= 1'b1;
              r_wb_sel <= bus.cmd_sel;
              r_state  <= REQ;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.wdat_valid) begin
            r_wdat       <= bus.wdat;
            r_wdat_ready <= 1'b0;
            r_stb        <= 1'b1;
            r_wb_we      <= 1'b1;
            r_wb_sel     <= r_sel;
            r_state      <= REQ;
`ifdef WB_MASTER_TIMEOUT_EN
            r_to         <= '0;
`endif
          end
        end
        REQ: begin
          // A read beat after the first enters here with stb low to leave the mandatory gap.
          if (!r_stb) begin
            r_stb    <= 1'b1;
            r_wb_we  <= r_we;
            r_wb_sel <= r_sel;
          end else if (bus.wb_ack_i) begin
            r_stb    <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_sel <= '0;
            r_addr   <= r_addr + AW'(BW);
            r_cnt    <= r_cnt - 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            r_to     <= '0;
`endif
            if (!r_we) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= bus.wb_dat_i;
            end
            if (r_cnt == '0) begin
              r_cyc     <= 1'b0;
              r_busy    <= 1'b0;
              r_rd_last <= 1'b1;
              r_state   <= DONE;
            end else if (r_we) begin
              r_wdat_ready <= 1'b1;
              r_state      <= FETCH;
            end
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (r_to == TW'(TIMEOUT - 1)) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_sel <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
            r_to     <= '0;
            r_state  <= IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
`endif
        end
        DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.wdat_ready = r_wdat_ready;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_last    = r_rd_last;
  assign bus.busy       = r_busy;
  assign bus.wb_cyc_o   = r_cyc;
  assign bus.wb_stb_o   = r_stb;
  assign bus.wb_we_o    = r_wb_we;
  assign bus.wb_addr_o  = r_addr;
  assign bus.wb_dat_o   = r_wdat;
  assign bus.wb_sel_o   = r_wb_sel;
`ifdef WB_MASTER_TIMEOUT_EN
  assign bus.err        = r_err;
`else
  assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a delay-programmable Wishbone slave and write-data feeder.
`timescale 1ns/1ps
module tb_wb_burst_master;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int BW = DW / 8;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  wb_burst_master_if #(.AW(AW), .DW(DW), .LW(LW)) bus_if ();

  wb_burst_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TMO)) dut (
    .sys_clk (clk),
    .RESETN  (rst_n),
    .bus     (bus_if)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic we; logic [BW-1:0] sel; } ack_t;
  typedef struct { logic [DW-1:0] d; int gap; } wbeat_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ack_t          alog[$];
  wbeat_t        wq[$];
  int            dly_q[$];
  logic [DW-1:0] rdq[$];
  logic [DW-1:0] rq[$];
  bit            no_ack = 1'b0;

  int viol = 0, cyc_rise = 0, stb_hi = 0, cyc_idle = 0;
  int rdv = 0, rdl = 0, lastv = 0, errc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] len,
                          input logic [BW-1:0] sel, input string tag);
    int n;
    n = 0;
    bus_if.cmd_we    = we;
    bus_if.cmd_addr  = a;
    bus_if.cmd_len   = len;
    bus_if.cmd_sel   = sel;
    bus_if.cmd_valid = 1'b1;
    while (!bus_if.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 64'(bus_if.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus_if.busy && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(bus_if.busy), 64'd0);
    tick();
    tick();
  endtask

  // Wishbone slave: ack after a per-beat delay, log what was presented at the ack.
  initial begin
    int wcnt, cur;
    wcnt = 0;
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      bus_if.wb_ack_i = 1'b0;
      if (!(bus_if.wb_cyc_o && bus_if.wb_stb_o)) begin
        wcnt = 0;
      end else if (!no_ack) begin
        cur = (dly_q.size() > 0) ? dly_q[0] : 0;
        if (wcnt >= cur) begin
          bus_if.wb_ack_i = 1'b1;
          if (dly_q.size() > 0) dly_q.delete(0);
          if (rdq.size() > 0) begin
            bus_if.wb_dat_i = rdq[0];
            rdq.delete(0);
          end else begin
            bus_if.wb_dat_i = DW'(bus_if.wb_addr_o) ^ 32'hA5A5_0000;
          end
          alog.push_back('{bus_if.wb_addr_o, bus_if.wb_dat_o, bus_if.wb_we_o, bus_if.wb_sel_o});
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Write-data feeder: each beat waits its gap (in cycles) after the previous beat is taken.
  initial begin
    int  gap_cnt;
    bit  take;
    gap_cnt = 0;
    take = 1'b0;
    bus_if.wdat_valid = 1'b0;
    bus_if.wdat = '0;
    forever begin
      @(negedge clk);
      if (take) begin
        wq.delete(0);
        take = 1'b0;
        gap_cnt = 0;
      end
      if (wq.size() == 0) begin
        bus_if.wdat_valid = 1'b0;
      end else if (gap_cnt < wq[0].gap) begin
        gap_cnt++;
        bus_if.wdat_valid = 1'b0;
      end else begin
        bus_if.wdat_valid = 1'b1;
        bus_if.wdat = wq[0].d;
        if (bus_if.wdat_ready) take = 1'b1;
      end
    end
  end

  // Protocol monitor and event counters.
  initial begin
    logic          p_cyc, p_stb, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_dat;
    logic [BW-1:0] p_sel;
    p_cyc = 0; p_stb = 0; p_we = 0; p_addr = '0; p_dat = '0; p_sel = '0;
    forever begin
      @(negedge clk);
      if (bus_if.wb_stb_o && !bus_if.wb_cyc_o) viol++;
      if (bus_if.wb_we_o && !bus_if.wb_stb_o) viol++;
      if (bus_if.wb_sel_o != '0 && !(bus_if.wb_stb_o && bus_if.wb_cyc_o)) viol++;
      if (bus_if.busy && bus_if.cmd_ready) viol++;
      if (bus_if.wb_stb_o && p_stb && (bus_if.wb_addr_o != p_addr || bus_if.wb_dat_o != p_dat ||
          bus_if.wb_sel_o != p_sel || bus_if.wb_we_o != p_we)) viol++;
      if (bus_if.wb_cyc_o && !p_cyc) cyc_rise++;
      if (bus_if.wb_stb_o) stb_hi++;
      if (bus_if.wb_cyc_o && !bus_if.wb_stb_o) cyc_idle++;
      if (bus_if.rd_valid) begin
        rdv++;
        rq.push_back(bus_if.rd_data);
      end
      if (bus_if.rd_last) rdl++;
      if (bus_if.rd_last && bus_if.rd_valid) lastv++;
      if (bus_if.err) errc++;
      p_cyc = bus_if.wb_cyc_o; p_stb = bus_if.wb_stb_o; p_we = bus_if.wb_we_o;
      p_addr = bus_if.wb_addr_o; p_dat = bus_if.wb_dat_o; p_sel = bus_if.wb_sel_o;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_stb, s_rdl, s_rdv, s_rise, s_idle, s_lastv, s_err, n;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.cmd_sel   = '0;

    // Reset state
    tick();
    tick();
    check("rst_ctrl", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_sel_o,
                           bus_if.cmd_ready, bus_if.wdat_ready, bus_if.rd_valid, bus_if.rd_last,
                           bus_if.busy, bus_if.err}), 64'd0);
    check("rst_addr", 64'(bus_if.wb_addr_o), 64'd0);
    check("rst_dat", 64'(bus_if.wb_dat_o), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);

    // Single read, 1-cycle latency path
    alog.delete(); rq.delete();
    rdq.push_back(32'hDEAD_BEEF);
    send_cmd(1'b0, 26'h100, 8'd0, 4'hF, "rd1");
    check("rd1_t1_stb", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o}), 64'b110);
    check("rd1_t1_addr", 64'(bus_if.wb_addr_o), 64'h100);
    check("rd1_t1_sel", 64'(bus_if.wb_sel_o), 64'hF);
    check("rd1_t1_busy", 64'({bus_if.busy, bus_if.cmd_ready}), 64'b10);
    @(posedge clk); #1;
    check("rd1_t2_valid", 64'({bus_if.rd_valid, bus_if.rd_last}), 64'b11);
    check("rd1_t2_data", 64'(bus_if.rd_data), 64'hDEAD_BEEF);
    check("rd1_t2_cyc", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.busy}), 64'b000);
    @(posedge clk); #1;
    check("rd1_t3", 64'({bus_if.rd_valid, bus_if.rd_last, bus_if.cmd_ready}), 64'b001);
    tick();

    // Write burst, ack delays 0/2/0/3
    alog.delete();
    for (int i = 1; i <= 4; i++) wq.push_back('{DW'(i), 0});
    dly_q = '{0, 2, 0, 3};
    s_stb = stb_hi; s_rdl = rdl; s_rdv = rdv; s_rise = cyc_rise;
    send_cmd(1'b1, 26'h200, 8'd3, 4'hC, "wr4");
    wait_idle("wr4");
    check("wr4_acks", 64'(alog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr4_addr%0d", i), 64'(alog[i].a), 64'(26'h200 + 4 * i));
      check($sformatf("wr4_dat%0d", i), 64'(alog[i].d), 64'(i + 1));
      check($sformatf("wr4_we_sel%0d", i), 64'({alog[i].we, alog[i].sel}), 64'b11100);
    end
    check("wr4_stb_cycles", 64'(stb_hi - s_stb), 64'd9);
    check("wr4_rd_last", 64'(rdl - s_rdl), 64'd1);
    check("wr4_rd_valid", 64'(rdv - s_rdv), 64'd0);
    check("wr4_one_cyc", 64'(cyc_rise - s_rise), 64'd1);

    // Write-data starvation before beat 2
    alog.delete();
    wq.push_back('{32'hA0A0_0001, 0});
    wq.push_back('{32'hA0A0_0002, 5});
    wq.push_back('{32'hA0A0_0003, 0});
    s_stb = stb_hi; s_idle = cyc_idle; s_rise = cyc_rise;
    send_cmd(1'b1, 26'h300, 8'd2, 4'hF, "starve");
    wait_idle("starve");
    check("starve_acks", 64'(alog.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("starve_addr%0d", i), 64'(alog[i].a), 64'(26'h300 + 4 * i));
      check($sformatf("starve_dat%0d", i), 64'(alog[i].d), 64'(32'hA0A0_0001 + i));
    end
    check("starve_idle_cycles", 64'(cyc_idle - s_idle), 64'd7);
    check("starve_stb_cycles", 64'(stb_hi - s_stb), 64'd3);
    check("starve_one_cyc", 64'(cyc_rise - s_rise), 64'd1);

    // Address wrap at 2^AW
    alog.delete(); rq.delete();
    rdq.push_back(32'h1111_1111);
    rdq.push_back(32'h2222_2222);
    s_rdl = rdl; s_lastv = lastv;
    send_cmd(1'b0, 26'h3FF_FFFC, 8'd1, 4'hF, "wrap");
    wait_idle("wrap");
    check("wrap_addr0", 64'(alog[0].a), 64'h3FF_FFFC);
    check("wrap_addr1", 64'(alog[1].a), 64'h0);
    check("wrap_rd_count", 64'(rq.size()), 64'd2);
    check("wrap_rd0", 64'(rq[0]), 64'h1111_1111);
    check("wrap_rd1", 64'(rq[1]), 64'h2222_2222);
    check("wrap_last_with_valid", 64'(lastv - s_lastv), 64'd1);
    check("wrap_rd_last", 64'(rdl - s_rdl), 64'd1);

    // Maximum length: 256 beats
    alog.delete(); rq.delete();
    s_rdv = rdv; s_lastv = lastv;
    send_cmd(1'b0, 26'h1000, 8'hFF, 4'hF, "long");
    wait_idle("long");
    check("long_acks", 64'(alog.size()), 64'd256);
    check("long_last_addr", 64'(alog[255].a), 64'h13FC);
    check("long_rd_count", 64'(rdv - s_rdv), 64'd256);
    check("long_last_data", 64'(rq[255]), 64'hA5A5_13FC);
    check("long_last_with_valid", 64'(lastv - s_lastv), 64'd1);

    // Reset during beat 2 of a 4-beat read
    alog.delete();
    dly_q = '{2, 2, 2, 2};
    s_rdl = rdl;
    send_cmd(1'b0, 26'h400, 8'd3, 4'hF, "rstmid");
    n = 0;
    while (!(alog.size() == 1 && bus_if.wb_stb_o) && n < 100) begin
      tick();
      n++;
    end
    check("rstmid_reach_beat2", 64'(alog.size() == 1 && bus_if.wb_stb_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_bus", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_sel_o}), 64'd0);
    check("rstmid_status", 64'({bus_if.busy, bus_if.cmd_ready, bus_if.rd_valid, bus_if.rd_last}), 64'd0);
    tick();
    tick();
    dly_q.delete();
    rst_n = 1'b1;
    tick();
    check("rstmid_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    check("rstmid_no_last", 64'(rdl - s_rdl), 64'd0);

`ifdef WB_MASTER_TIMEOUT_EN
    // Slave never acks: burst aborted after TIMEOUT strobe cycles
    no_ack = 1'b1;
    s_stb = stb_hi; s_err = errc; s_rdl = rdl;
    send_cmd(1'b0, 26'h500, 8'd1, 4'hF, "tmo");
    n = 0;
    while (errc == s_err && n < 100) begin
      tick();
      n++;
    end
    check("tmo_err_pulse", 64'(bus_if.err), 64'd1);
    check("tmo_bus_idle", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.busy}), 64'd0);
    check("tmo_stb_cycles", 64'(stb_hi - s_stb), 64'd8);
    tick();
    check("tmo_err_one_cycle", 64'(errc - s_err), 64'd1);
    check("tmo_no_last", 64'(rdl - s_rdl), 64'd0);
    no_ack = 1'b0;
    send_cmd(1'b0, 26'h600, 8'd0, 4'hF, "tmo_next");
    wait_idle("tmo_next");
    check("tmo_next_last", 64'(rdl - s_rdl), 64'd1);
`else
    check("no_err_ever", 64'(errc), 64'd0);
`endif

    check("protocol_violations", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
